// File: rtl/banner_pkg.sv
// banner_pkg: PS/2 make codes, symbol geometry and helpers shared by the banner scroller.
package banner_pkg;
   localparam int SYM_W = 5;
   typedef logic [SYM_W-1:0] sym_t;
   localparam logic [7:0] KC_GO      = 8'h34;
   localparam logic [7:0] KC_PAUSE   = 8'h4D;
   localparam logic [7:0] KC_DIR     = 8'h23;
   localparam logic [7:0] KC_BKSP    = 8'h66;
   localparam logic [7:0] KC_DP      = 8'h49;
   localparam logic [7:0] KC_FAST    = 8'h79;
   localparam logic [7:0] KC_SLOW    = 8'h7B;
   localparam logic [7:0] KC_RESTORE = 8'h2D;
   localparam logic [7:0] KC_D0      = 8'h45;
   localparam logic [7:0] KC_D1      = 8'h16;
   localparam logic [7:0] KC_D2      = 8'h1E;
   localparam logic [7:0] KC_D3      = 8'h26;
   localparam logic [7:0] KC_D4      = 8'h25;
   localparam logic [7:0] KC_D5      = 8'h2E;
   localparam logic [7:0] KC_D6      = 8'h36;
   localparam logic [7:0] KC_D7      = 8'h3D;
   localparam logic [7:0] KC_D8      = 8'h3E;
   localparam logic [7:0] KC_D9      = 8'h46;
   // returns {hit, nibble}; hit is 0 for non-digit codes
   function automatic logic [4:0] dig_decode(input logic [7:0] code);
      case (code)
         KC_D0: return 5'h10;
         KC_D1: return 5'h11;
         KC_D2: return 5'h12;
         KC_D3: return 5'h13;
         KC_D4: return 5'h14;
         KC_D5: return 5'h15;
         KC_D6: return 5'h16;
         KC_D7: return 5'h17;
         KC_D8: return 5'h18;
         KC_D9: return 5'h19;
         default: return 5'h00;
      endcase
   endfunction
   function automatic sym_t rst_sym(input int i);
      return SYM_W'(i % 16);
   endfunction
endpackage

// File: rtl/banner_tick_gen.sv
// banner_tick_gen: speed-scaled period counter; ticks when cnt reaches TICK_MAX >> speed.
module banner_tick_gen #(
   parameter int TICK_MAX = 15_000_000,
   parameter int CNT_W    = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] speed,
   input  logic [1:0] speed_nxt,
   input  logic       speed_chg,
   output logic       tick
);
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] p;
   logic [CNT_W-1:0] p_nxt;
   assign p     = CNT_W'(TICK_MAX >> speed);
   assign p_nxt = CNT_W'(TICK_MAX >> speed_nxt);
   assign tick  = en && cnt == p;
   // a shorter period that cnt has already passed restarts the count instead of ticking
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (speed_chg && cnt > p_nxt) cnt <= '0;
      else if (tick) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/banner_scroller.sv
// banner_scroller: circular seven-segment banner with scroll, edit and speed commands
// taken from a valid/ready stream of PS/2 make codes.
module banner_scroller
   import banner_pkg::*;
#(
   parameter int DIGITS   = 6,
   parameter int LEN      = 10,
   parameter int SYM_W    = 5,
   parameter int TICK_MAX = 15_000_000,
   parameter int CNT_W    = 25
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   input  logic [7:0]              cmd_data,
   output logic                    cmd_ready,
   output logic [DIGITS*SYM_W-1:0] digits,
   output logic                    running,
   output logic                    dir,
   output logic [1:0]              speed
);
   logic [SYM_W-1:0] sym [LEN];
   logic             tick;
   logic             acc;
   logic [4:0]       dig;
   logic [1:0]       speed_nxt;
   assign cmd_ready = !tick;
   assign acc       = cmd_valid && cmd_ready;
   assign dig       = dig_decode(cmd_data);
   assign speed_nxt = !acc ? speed :
                      (cmd_data == KC_FAST && speed != 2'd3) ? speed + 2'd1 :
                      (cmd_data == KC_SLOW && speed != 2'd0) ? speed - 2'd1 : speed;
   banner_tick_gen #(.TICK_MAX(TICK_MAX), .CNT_W(CNT_W)) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (running),
      .speed    (speed),
      .speed_nxt(speed_nxt),
      .speed_chg(speed_nxt != speed),
      .tick     (tick)
   );
   always_comb
      for (int k = 0; k < DIGITS; k++) digits[k*SYM_W +: SYM_W] = sym[DIGITS-1-k];
   // tick and accept are mutually exclusive, so rotation and edits never share an edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < LEN; i++) sym[i] <= SYM_W'(rst_sym(i));
         running <= 1'b0;
         dir     <= 1'b0;
         speed   <= 2'd0;
      end else begin
         speed <= speed_nxt;
         if (tick)
            for (int i = 0; i < LEN; i++) sym[i] <= dir ? sym[(i+LEN-1)%LEN] : sym[(i+1)%LEN];
         else if (acc) begin
            if (dig[4]) begin
               sym[0] <= {{(SYM_W-4){1'b0}}, dig[3:0]};
               for (int i = 1; i < LEN; i++) sym[i] <= sym[i-1];
            end
            case (cmd_data)
               KC_GO:    running <= 1'b1;
               KC_PAUSE: running <= 1'b0;
               KC_DIR:   dir <= !dir;
               KC_DP:    sym[0][SYM_W-1] <= !sym[0][SYM_W-1];
               KC_BKSP: begin
                  for (int i = 0; i < LEN-1; i++) sym[i] <= sym[i+1];
                  sym[LEN-1] <= '0;
               end
               KC_RESTORE:
                  for (int i = 0; i < LEN; i++) sym[i] <= SYM_W'(rst_sym(i));
               default: ;
            endcase
         end
      end
endmodule
